// File: rtl/eq_delay_sweep_ctrl.sv
// Sweeps each of the six edge-delay settings through 0..MAX_DELAY and counts
// selected-channel errors over DWELL_FRAMES frames, then commits the lowest-error setting.
module eq_delay_sweep_ctrl #(
    parameter int MAX_DELAY    = 9,
    parameter int SETTLE_CYC   = 16,
    parameter int DWELL_FRAMES = 4,
    parameter int ERR_W        = 16
) (
    input  logic       clk_x10,
    input  logic       g_rst,
    input  logic       start,
    input  logic       frame_tick,
    input  logic [2:0] err,
    output logic [3:0] rising_delay_r,
    output logic [3:0] falling_delay_r,
    output logic [3:0] rising_delay_g,
    output logic [3:0] falling_delay_g,
    output logic [3:0] rising_delay_b,
    output logic [3:0] falling_delay_b,
    output logic       busy,
    output logic       done,
    output logic [2:0] phase
);
    localparam int SC_W = $clog2(SETTLE_CYC + 1);
    localparam int FC_W = $clog2(DWELL_FRAMES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_COMPARE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [2:0]      phase_q, phase_d;
    logic [3:0]      trial_q, trial_d;
    logic [ERR_W-1:0] best_err_q, best_err_d;
    logic [3:0]      best_set_q, best_set_d;
    logic [ERR_W-1:0] err_acc_q, err_acc_d;
    logic [SC_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]      dly_q [6];
    logic [3:0]      dly_d [6];

    logic [1:0]      ch_sel;
    logic            err_hit;
    logic            lower;
    logic            wr_cur;
    logic            wr_next;
    logic [3:0]      wr_val;

    // phase/2 picks R,G,B; err is packed R at bit 2 down to B at bit 0
    assign ch_sel  = 2'd2 - phase_q[2:1];
    assign err_hit = err[ch_sel];
    assign lower   = err_acc_q < best_err_q;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        trial_d      = trial_q;
        best_err_d   = best_err_q;
        best_set_d   = best_set_q;
        err_acc_d    = err_acc_q;
        settle_cnt_d = settle_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        dly_d        = dly_q;
        wr_cur       = 1'b0;
        wr_next      = 1'b0;
        wr_val       = 4'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_SETTLE;
                    phase_d      = 3'd0;
                    trial_d      = 4'd0;
                    best_err_d   = '1;
                    best_set_d   = 4'd0;
                    settle_cnt_d = '0;
                    dly_d[0]     = 4'd0;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == SC_W'(SETTLE_CYC - 1)) begin
                    state_d     = S_MEASURE;
                    err_acc_d   = '0;
                    frame_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            S_MEASURE: begin
                if (err_hit && (err_acc_q != {ERR_W{1'b1}})) begin
                    err_acc_d = err_acc_q + 1'b1;
                end
                if (frame_tick) begin
                    if (frame_cnt_q == FC_W'(DWELL_FRAMES - 1)) begin
                        state_d = S_COMPARE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            S_COMPARE: begin
                settle_cnt_d = '0;
                wr_cur       = 1'b1;
                if (lower) begin
                    best_err_d = err_acc_q;
                    best_set_d = trial_q;
                end
                if (trial_q < 4'(MAX_DELAY)) begin
                    trial_d = trial_q + 4'd1;
                    wr_val  = trial_q + 4'd1;
                    state_d = S_SETTLE;
                end else begin
                    wr_val = lower ? trial_q : best_set_q;
                    if (phase_q < 3'd5) begin
                        wr_next    = 1'b1;
                        phase_d    = phase_q + 3'd1;
                        trial_d    = 4'd0;
                        best_err_d = '1;
                        best_set_d = 4'd0;
                        state_d    = S_SETTLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                phase_d = 3'd0;
            end
            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < 6; i++) begin
            if (wr_cur && (phase_q == 3'(i))) begin
                dly_d[i] = wr_val;
            end
            if (wr_next && ((phase_q + 3'd1) == 3'(i))) begin
                dly_d[i] = 4'd0;
            end
        end
    end

    always_ff @(posedge clk_x10) begin
        if (g_rst) begin
            state_q      <= S_IDLE;
            phase_q      <= 3'd0;
            trial_q      <= 4'd0;
            best_err_q   <= '0;
            best_set_q   <= 4'd0;
            err_acc_q    <= '0;
            settle_cnt_q <= '0;
            frame_cnt_q  <= '0;
            for (int i = 0; i < 6; i++) begin
                dly_q[i] <= 4'd0;
            end
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            trial_q      <= trial_d;
            best_err_q   <= best_err_d;
            best_set_q   <= best_set_d;
            err_acc_q    <= err_acc_d;
            settle_cnt_q <= settle_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            dly_q        <= dly_d;
        end
    end

    assign rising_delay_r  = dly_q[0];
    assign falling_delay_r = dly_q[1];
    assign rising_delay_g  = dly_q[2];
    assign falling_delay_g = dly_q[3];
    assign rising_delay_b  = dly_q[4];
    assign falling_delay_b = dly_q[5];
    assign busy  = (state_q == S_SETTLE) || (state_q == S_MEASURE) || (state_q == S_COMPARE);
    assign done  = (state_q == S_DONE);
    assign phase = phase_q;

endmodule

// File: tb/tb_eq_delay_sweep_ctrl.sv
// Bench for eq_delay_sweep_ctrl: a procedural sweep timeline predicts every output each cycle.
module tb_eq_delay_sweep_ctrl;
    localparam int MAXD    = 9;
    localparam int SET     = 16;
    localparam int DW      = 4;
    localparam int EW      = 4;
    localparam int F       = 8;
    localparam int ACC_MAX = (1 << EW) - 1;

    logic       clk = 1'b0;
    logic       g_rst, start, frame_tick;
    logic [2:0] err;
    logic [3:0] rising_delay_r, falling_delay_r, rising_delay_g;
    logic [3:0] falling_delay_g, rising_delay_b, falling_delay_b;
    logic       busy, done;
    logic [2:0] phase;

    always #5 clk = ~clk;

    eq_delay_sweep_ctrl #(
        .MAX_DELAY(MAXD), .SETTLE_CYC(SET), .DWELL_FRAMES(DW), .ERR_W(EW)
    ) u_dut (
        .clk_x10(clk), .g_rst(g_rst), .start(start), .frame_tick(frame_tick), .err(err),
        .rising_delay_r(rising_delay_r), .falling_delay_r(falling_delay_r),
        .rising_delay_g(rising_delay_g), .falling_delay_g(falling_delay_g),
        .rising_delay_b(rising_delay_b), .falling_delay_b(falling_delay_b),
        .busy(busy), .done(done), .phase(phase)
    );

    logic [3:0] dut_dly [6];
    assign dut_dly[0] = rising_delay_r;
    assign dut_dly[1] = falling_delay_r;
    assign dut_dly[2] = rising_delay_g;
    assign dut_dly[3] = falling_delay_g;
    assign dut_dly[4] = rising_delay_b;
    assign dut_dly[5] = falling_delay_b;

    logic [3:0] exp_dly [6];
    logic [3:0] nx_dly [6];
    logic       exp_busy, nx_busy, exp_done, nx_done;
    logic [2:0] exp_phase, nx_phase;
    bit         chk_en = 1'b0;
    int         checks = 0;
    int         failures = 0;
    int         gc = 0;
    int         done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("phase", 32'(phase), 32'(exp_phase));
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("dly%0d", i), 32'(dut_dly[i]), 32'(exp_dly[i]));
            end
        end
        if (done === 1'b1) done_seen++;
    end

    function automatic bit tick_now();
        return (gc % F) == (F - 1);
    endfunction

    // Error stimulus per scenario; meas=1 during the measurement window, last=completing frame
    function automatic logic [2:0] pat(input int tid, input int p, input int t,
                                       input bit meas, input bit tk, input bit last);
        logic [2:0] e;
        e = 3'b000;
        case (tid)
            2: begin
                if (tk && !(p == 0 && t == 4)) e[2] = 1'b1;
                if (tk && p == 0 && t == 4) e[1:0] = 2'b11;
            end
            3: begin
                if (p == 3 && t <= 8) e[1] = 1'b1;
                if (p >= 4 && t == 0 && !meas) e[0] = 1'b1;
                if (p == 5 && last && t != 6) e[0] = 1'b1;
            end
            default: e = 3'b000;
        endcase
        return e;
    endfunction

    task automatic cyc(input logic s, input logic [2:0] e, input logic r);
        start      = s;
        err        = e;
        g_rst      = r;
        frame_tick = tick_now();
        @(posedge clk);
        exp_dly   = nx_dly;
        exp_busy  = nx_busy;
        exp_done  = nx_done;
        exp_phase = nx_phase;
        gc++;
        #1;
    endtask

    // One full calibration; optional reset abort at (ab_p, ab_t) and stray start during phase st_p
    task automatic sweep(input int tid, input int ab_p, input int ab_t, input int st_p);
        int         acc, best_err, best_set, nfr;
        bit         tk, last;
        logic [2:0] e;
        nx_busy   = 1'b1;
        nx_phase  = 3'd0;
        nx_dly[0] = 4'd0;
        cyc(1'b1, 3'b000, 1'b0);
        for (int p = 0; p < 6; p++) begin
            best_err = ACC_MAX;
            best_set = 0;
            for (int t = 0; t <= MAXD; t++) begin
                if (p == ab_p && t == ab_t) begin
                    for (int i = 0; i < 6; i++) nx_dly[i] = 4'd0;
                    nx_busy  = 1'b0;
                    nx_done  = 1'b0;
                    nx_phase = 3'd0;
                    cyc(1'b0, 3'b000, 1'b1);
                    return;
                end
                for (int s = 0; s < SET; s++) begin
                    tk = tick_now();
                    cyc((p == st_p && t == 1 && s == 3), pat(tid, p, t, 1'b0, tk, 1'b0), 1'b0);
                end
                acc = 0;
                nfr = 0;
                forever begin
                    tk   = tick_now();
                    last = tk && (nfr == DW - 1);
                    e    = pat(tid, p, t, 1'b1, tk, last);
                    if (e[2 - p / 2] && acc < ACC_MAX) acc++;
                    if (tk) nfr++;
                    cyc(1'b0, e, 1'b0);
                    if (last) break;
                end
                if (acc < best_err) begin
                    best_err = acc;
                    best_set = t;
                end
                if (t < MAXD) begin
                    nx_dly[p] = 4'(t + 1);
                end else begin
                    nx_dly[p] = 4'(best_set);
                    if (p < 5) begin
                        nx_phase      = 3'(p + 1);
                        nx_dly[p + 1] = 4'd0;
                    end else begin
                        nx_busy = 1'b0;
                        nx_done = 1'b1;
                    end
                end
                cyc(1'b0, 3'b000, 1'b0);
            end
        end
        nx_done  = 1'b0;
        nx_phase = 3'd0;
        cyc(1'b0, 3'b000, 1'b0);
        cyc(1'b0, 3'b000, 1'b0);
        cyc(1'b0, 3'b000, 1'b0);
    endtask

    initial begin
        start = 1'b0; frame_tick = 1'b0; err = 3'b000; g_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            nx_dly[i]  = 4'd0;
            exp_dly[i] = 4'd0;
        end
        nx_busy = 1'b0; nx_done = 1'b0; nx_phase = 3'd0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_phase = 3'd0;
        cyc(1'b0, 3'b000, 1'b1);
        cyc(1'b0, 3'b000, 1'b1);
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_rising_r", 32'(rising_delay_r), 0);
        cyc(1'b0, 3'b000, 1'b0);

        // No errors: every trial ties, lowest delay wins everywhere
        sweep(1, -1, -1, -1);
        for (int i = 0; i < 6; i++) chk($sformatf("quiet_dly%0d", i), 32'(dut_dly[i]), 0);
        chk("quiet_done_pulses", 32'(done_seen), 1);

        // Red errors except R-rise trial 4; stray start mid-sweep is ignored
        sweep(2, -1, -1, 2);
        chk("red_rising_r", 32'(rising_delay_r), 4);
        chk("red_falling_r", 32'(falling_delay_r), 0);
        chk("red_rising_g", 32'(rising_delay_g), 0);
        chk("red_done_pulses", 32'(done_seen), 2);

        // Settle-window errors ignored, saturation on G-fall, final-frame errors on B-fall
        sweep(3, -1, -1, -1);
        chk("mix_rising_r", 32'(rising_delay_r), 0);
        chk("mix_falling_g", 32'(falling_delay_g), 9);
        chk("mix_rising_b", 32'(rising_delay_b), 0);
        chk("mix_falling_b", 32'(falling_delay_b), 6);

        // Reset during G-fall aborts and clears everything
        sweep(1, 3, 2, -1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_phase", 32'(phase), 0);
        chk("abort_falling_b", 32'(falling_delay_b), 0);
        cyc(1'b0, 3'b000, 1'b0);
        cyc(1'b0, 3'b000, 1'b0);
        chk("abort_done_pulses", 32'(done_seen), 3);

        // Fresh start after the abort runs from phase 0
        sweep(2, -1, -1, -1);
        chk("restart_rising_r", 32'(rising_delay_r), 4);
        chk("restart_done_pulses", 32'(done_seen), 4);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
